// File: rtl/regbank_pkg.sv
// Shared definitions for the two-requester register bank.
//   DW_DEFAULT / AW_DEFAULT : default data width and address width
//   req_idx_e               : requester index, also used as the priority pointer
package regbank_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 2;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_e;

endpackage : regbank_pkg

// File: rtl/regbank.sv
// Register storage: 2**AW registers of DW bits behind one access port.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears every register
//   we    : write strobe for the current access
//   addr  : register address
//   wdata : write data
//   rdata : combinational read of register addr (the caller registers it)
module regbank
  import regbank_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] mem_q [NREG];

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent behaviour.
  // NOTE: the array is reset explicitly because registers must read zero
  // after reset; this makes it flops rather than an inferred RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // A write lands at the edge, so a read on the following cycle sees it.
  assign rdata = mem_q[addr];

endmodule : regbank

// File: rtl/regbank_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register bank.
// Ports (N = 0, 1):
//   clk, rst : rising-edge clock, synchronous active-high reset
//   reqN     : access request, held stable until gntN
//   weN      : 1 = write, 0 = read
//   addrN    : register address
//   wdataN   : write data
//   gntN     : combinational grant (at most one high per cycle)
//   rvalidN  : one-cycle pulse, one cycle after a granted read
//   rdataN   : registered read data, holds between reads
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1
);

  req_idx_e      prio_q, prio_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic          bank_we;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata, bank_rdata;

  // Grant depends only on the requests and the priority pointer; reset
  // masks both grants so nothing reaches the bank while rst is high.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && (!req1 || prio_q == REQ0)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Steer the winner onto the single bank port.
  always_comb begin
    bank_we    = (gnt0 & we0) | (gnt1 & we1);
    bank_addr  = gnt1 ? addr1  : addr0;
    bank_wdata = gnt1 ? wdata1 : wdata0;
  end

  // The pointer moves to the other requester after each grant, which gives
  // strict alternation when both keep requesting.
  always_comb begin
    prio_d = prio_q;
    if (gnt0) begin
      prio_d = REQ1;
    end else if (gnt1) begin
      prio_d = REQ0;
    end
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? bank_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? bank_rdata : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q    <= REQ0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

  regbank #(
    .DW (DW),
    .AW (AW)
  ) u_regbank (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

endmodule : regbank_arbiter

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter: directed scenarios plus a
// randomized run, all compared against a behavioural model of the bank.
module tb_regbank_arbiter;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NREG = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [DW-1:0] m_mem [NREG];
  int            m_prio;
  logic          m_rv0, m_rv1;
  logic [DW-1:0] m_rd0, m_rd1;
  logic          last_g0, last_g1;

  always #5 clk = ~clk;

  regbank_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .we0     (we0),
    .addr0   (addr0),
    .wdata0  (wdata0),
    .gnt0    (gnt0),
    .rvalid0 (rvalid0),
    .rdata0  (rdata0),
    .req1    (req1),
    .we1     (we1),
    .addr1   (addr1),
    .wdata1  (wdata1),
    .gnt1    (gnt1),
    .rvalid1 (rvalid1),
    .rdata1  (rdata1)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  // One clock cycle: check grants against the model mid-cycle, advance the
  // model at the edge, then check the registered read outputs.
  task automatic cycle();
    logic e_g0, e_g1;
    #1;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        if (m_prio == 0) e_g0 = 1'b1; else e_g1 = 1'b1;
      end else begin
        e_g0 = req0;
        e_g1 = req1;
      end
    end
    checks++;
    if ({gnt0, gnt1} !== {e_g0, e_g1}) begin
      errors++;
      $display("FAIL grant @%0t: got gnt0=%b gnt1=%b, expected %b %b", $time, gnt0, gnt1, e_g0, e_g1);
    end
    last_g0 = gnt0;
    last_g1 = gnt1;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      m_prio = 0;
      m_rv0 = 1'b0; m_rv1 = 1'b0;
      m_rd0 = '0;   m_rd1 = '0;
    end else begin
      m_rv0 = 1'b0;
      m_rv1 = 1'b0;
      if (e_g0) begin
        if (we0) m_mem[addr0] = wdata0;
        else begin m_rv0 = 1'b1; m_rd0 = m_mem[addr0]; end
        m_prio = 1;
      end else if (e_g1) begin
        if (we1) m_mem[addr1] = wdata1;
        else begin m_rv1 = 1'b1; m_rd1 = m_mem[addr1]; end
        m_prio = 0;
      end
    end
    #1;
    checks++;
    if ({rvalid0, rdata0, rvalid1, rdata1} !== {m_rv0, m_rd0, m_rv1, m_rd1}) begin
      errors++;
      $display("FAIL read_out @%0t: got rv0=%b rd0=%h rv1=%b rd1=%h, expected %b %h %b %h",
               $time, rvalid0, rdata0, rvalid1, rdata1, m_rv0, m_rd0, m_rv1, m_rd1);
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    // Requests during reset must neither be granted nor write the bank.
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd3; wdata0 = 8'hFF;
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd0; wdata1 = 8'hEE;
    cycle();
    cycle();
    checks++;
    if ({last_g0, last_g1, rvalid0, rvalid1, rdata0, rdata1} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: got g=%b%b rv=%b%b rd0=%h rd1=%h, expected all zero",
               last_g0, last_g1, rvalid0, rvalid1, rdata0, rdata1);
    end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_read_all();
    for (int a = 0; a < NREG; a++) begin
      idle();
      req0 = 1'b1; we0 = 1'b0; addr0 = AW'(a);
      cycle();
      checks++;
      if (last_g0 !== 1'b1 || rvalid0 !== 1'b1 || rdata0 !== 8'h00) begin
        errors++;
        $display("FAIL read_all[%0d]: got gnt0=%b rvalid0=%b rdata0=%h, expected 1 1 00",
                 a, last_g0, rvalid0, rdata0);
      end
    end
    idle();
    cycle();
    checks++;
    if (rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL read_all_pulse: got rvalid0=%b, expected 0", rvalid0);
    end
  endtask

  task automatic test_write_read();
    idle();
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 8'hA5;
    cycle();
    checks++;
    if (rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rvalid: got rvalid0=%b, expected 0", rvalid0);
    end
    we0 = 1'b0;
    cycle();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'hA5) begin
      errors++;
      $display("FAIL write_read: got rvalid0=%b rdata0=%h, expected 1 a5", rvalid0, rdata0);
    end
    idle();
    cycle();
  endtask

  task automatic test_contention();
    do_reset();
    req0 = 1'b1; we0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      addr0 = AW'($urandom_range(0, NREG - 1));
      addr1 = AW'($urandom_range(0, NREG - 1));
      cycle();
      checks++;
      if (last_g0 !== ((i % 2) == 0) || last_g1 !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL contention[%0d]: got gnt0=%b gnt1=%b, expected %0d %0d",
                 i, last_g0, last_g1, (i % 2) == 0, (i % 2) == 1);
      end
    end
    idle();
    cycle();
  endtask

  task automatic test_simul_write();
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd1; wdata1 = 8'h22;
    cycle();
    if (last_g0) req0 = 1'b0;
    cycle();
    idle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1;
    cycle();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h22) begin
      errors++;
      $display("FAIL simul_write: got rvalid0=%b rdata0=%h, expected 1 22", rvalid0, rdata0);
    end
    idle();
    cycle();
  endtask

  task automatic test_reset_mid_read();
    idle();
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd3; wdata1 = 8'h5C;
    cycle();
    we1 = 1'b0;
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (rvalid1 !== 1'b0 || rdata1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_read: got rvalid1=%b rdata1=%h, expected 0 00", rvalid1, rdata1);
    end
    for (int a = 0; a < NREG; a++) begin
      idle();
      req1 = 1'b1; we1 = 1'b0; addr1 = AW'(a);
      cycle();
      checks++;
      if (rvalid1 !== 1'b1 || rdata1 !== 8'h00) begin
        errors++;
        $display("FAIL reset_clears[%0d]: got rvalid1=%b rdata1=%h, expected 1 00", a, rvalid1, rdata1);
      end
    end
    idle();
    cycle();
  endtask

  task automatic test_req0_alone();
    logic [DW-1:0] vals [3];
    do_reset();
    for (int a = 0; a < 3; a++) begin
      vals[a] = DW'($urandom_range(1, 255));
      req0 = 1'b1; we0 = 1'b1; addr0 = AW'(a); wdata0 = vals[a];
      cycle();
    end
    for (int a = 0; a < 3; a++) begin
      req0 = 1'b1; we0 = 1'b0; addr0 = AW'(a);
      cycle();
      checks++;
      if (last_g0 !== 1'b1 || rvalid0 !== 1'b1 || rdata0 !== vals[a]) begin
        errors++;
        $display("FAIL req0_alone[%0d]: got gnt0=%b rvalid0=%b rdata0=%h, expected 1 1 %h",
                 a, last_g0, rvalid0, rdata0, vals[a]);
      end
    end
    // Pointer should now sit at requester 1.
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd0;
    cycle();
    checks++;
    if (last_g1 !== 1'b1 || last_g0 !== 1'b0) begin
      errors++;
      $display("FAIL prio_after_req0: got gnt0=%b gnt1=%b, expected 0 1", last_g0, last_g1);
    end
    idle();
    cycle();
  endtask

  task automatic test_random();
    bit pend0 = 1'b0;
    bit pend1 = 1'b0;
    idle();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      // Hold a pending request stable, occasionally withdrawing it.
      if (!pend0 || $urandom_range(0, 7) == 0) begin
        req0 = $urandom_range(0, 1) == 1; we0 = $urandom_range(0, 1) == 1;
        addr0 = AW'($urandom_range(0, NREG - 1)); wdata0 = DW'($urandom);
      end
      if (!pend1 || $urandom_range(0, 7) == 0) begin
        req1 = $urandom_range(0, 1) == 1; we1 = $urandom_range(0, 1) == 1;
        addr1 = AW'($urandom_range(0, NREG - 1)); wdata1 = DW'($urandom);
      end
      cycle();
      pend0 = req0 && !last_g0;
      pend1 = req1 && !last_g1;
    end
    rst = 1'b0;
    idle();
    cycle();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_prio = 0;
    m_rv0 = 1'b0; m_rv1 = 1'b0;
    m_rd0 = '0;   m_rd1 = '0;
    rst = 1'b1;
    idle();

    test_reset();
    test_read_all();
    test_write_read();
    test_contention();
    test_simul_write();
    test_reset_mid_read();
    test_req0_alone();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regbank_arbiter
